ram_3d_port_arbiter: RTL and testbench



---
 rtl/ram_3d_pkg.sv | 26 ++
 rtl/ram_3d_port_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/ram_3d_port_arbiter.sv | 100 ++++++++++
 tb/tb_ram_3d_port_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ram_3d_pkg.sv
// Shared constants, helper and request type for the banked-RAM port-A arbiter.
package ram_3d_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_BANKS = 10;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_W    = 10;

  // Minimum bank-select width; never below one bit.
  function automatic int bank_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEF_BANK_W = bank_w(DEF_NUM_BANKS);

  typedef struct packed {
    logic                  we;
    logic [DEF_BANK_W-1:0] bank;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_WIDTH-1:0]  wdata;
  } req_t;

endpackage

// File: rtl/ram_3d_port_arbiter_if.sv
// Requester bus plus RAM port-A bus; master = requesters/RAM, slave = arbiter.
interface ram_3d_port_arbiter_if #(
  parameter int NUM_REQ   = ram_3d_pkg::DEF_NUM_REQ,
  parameter int NUM_BANKS = ram_3d_pkg::DEF_NUM_BANKS,
  parameter int WIDTH     = ram_3d_pkg::DEF_WIDTH,
  parameter int ADDR_W    = ram_3d_pkg::DEF_ADDR_W
);
  import ram_3d_pkg::*;
  localparam int BANK_W = bank_w(NUM_BANKS);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ-1:0][BANK_W-1:0]   req_bank;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0]    req_wdata;
  logic [NUM_REQ-1:0]               req_gnt;
  logic [NUM_REQ-1:0]               req_err;
  logic [NUM_REQ-1:0]               rd_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0]    rd_data;
  logic [NUM_BANKS-1:0]             ena;
  logic [NUM_BANKS-1:0]             wea;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] addra;
  logic [NUM_BANKS-1:0][WIDTH-1:0]  dina;
  logic [NUM_BANKS-1:0][WIDTH-1:0]  douta;

  modport master (
    output req_valid, req_we, req_bank, req_addr, req_wdata, douta,
    input  req_gnt, req_err, rd_valid, rd_data, ena, wea, addra, dina
  );

  modport slave (
    input  req_valid, req_we, req_bank, req_addr, req_wdata, douta,
    output req_gnt, req_err, rd_valid, rd_data, ena, wea, addra, dina
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins; pointer moves past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    idx   = 0;
    sel   = '0;
    gnt_o = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (req_i[sel] && (gnt_o == '0)) begin
        gnt_o[sel] = 1'b1;
        ptr_d      = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_3d_port_arbiter.sv
// Shares RAM port A across requesters with one round-robin arbiter per bank and
// returns read data to the granted requester one cycle after its grant.
module ram_3d_port_arbiter
  import ram_3d_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_3d_port_arbiter_if.slave bus
);
  localparam int BANK_W = bank_w(NUM_BANKS);

  logic [NUM_REQ-1:0]                 in_range;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0]  cand;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0]  bank_gnt;
  logic [NUM_REQ-1:0]                 gnt_any;
  logic [NUM_REQ-1:0]                 pend_valid_d, pend_valid_q;
  logic [NUM_REQ-1:0]                 err_d, err_q;
  logic [NUM_REQ-1:0][BANK_W-1:0]     pend_bank_d, pend_bank_q;
  logic [NUM_REQ-1:0][WIDTH-1:0]      rd_data_d, rd_data_q;

  always_comb begin
    in_range = '0;
    cand     = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      in_range[r] = int'(bus.req_bank[r]) < NUM_BANKS;
      for (int b = 0; b < NUM_BANKS; b++)
        cand[b][r] = bus.req_valid[r] && (bus.req_bank[r] == BANK_W'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst_n (rst),
      .req_i (cand[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  // Out-of-range requests are granted at once so the requester never stalls.
  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_any = gnt_any | bank_gnt[b];
    bus.req_gnt = {NUM_REQ{rst}} & (gnt_any | (bus.req_valid & ~in_range));
  end

  always_comb begin
    bus.ena   = '0;
    bus.wea   = '0;
    bus.addra = '0;
    bus.dina  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bank_gnt[b][r]) begin
          bus.ena[b]   = rst;
          bus.wea[b]   = rst & bus.req_we[r];
          bus.addra[b] = bus.req_addr[r];
          bus.dina[b]  = bus.req_wdata[r];
        end
      end
    end
  end

  assign pend_valid_d = bus.req_gnt & ~bus.req_we & in_range;
  assign err_d        = bus.req_gnt & ~in_range;
  assign pend_bank_d  = bus.req_bank;

  // RAM output is live only in the cycle after the access, so pass it through then hold it.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int r = 0; r < NUM_REQ; r++)
      if (pend_valid_q[r]) rd_data_d[r] = bus.douta[pend_bank_q[r]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_q <= '0;
      err_q        <= '0;
      rd_data_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_bank_q <= pend_bank_d;
  end

  assign bus.rd_valid = pend_valid_q;
  assign bus.rd_data  = rd_data_d;
  assign bus.req_err  = err_q;

endmodule

// File: tb/tb_ram_3d_port_arbiter.sv
// Directed bench for ram_3d_port_arbiter with a behavioural read-first banked RAM on port A.
module tb_ram_3d_port_arbiter;
  import ram_3d_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int NB = DEF_NUM_BANKS;
  localparam int W  = DEF_WIDTH;
  localparam int AW = DEF_ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_g [5];

  ram_3d_port_arbiter_if #(.NUM_REQ(NR), .NUM_BANKS(NB), .WIDTH(W), .ADDR_W(AW)) bus ();

  ram_3d_port_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [NB][1<<AW];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.ena[b]) begin
        if (bus.wea[b]) mem[b][bus.addra[b]] <= bus.dina[b];
        bus.douta[b] <= mem[b][bus.addra[b]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic req_t mk(input logic we, input int bank, input int addr, input int wdata);
    req_t q;
    q.we    = we;
    q.bank  = DEF_BANK_W'(bank);
    q.addr  = AW'(addr);
    q.wdata = W'(wdata);
    return q;
  endfunction

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_bank  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input logic [1:0] r, input req_t q);
    bus.req_valid[r] = 1'b1;
    bus.req_we[r]    = q.we;
    bus.req_bank[r]  = q.bank;
    bus.req_addr[r]  = q.addr;
    bus.req_wdata[r] = q.wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_reqs();

    // Reset: outputs cleared, grant and RAM enable suppressed even with a request present
    set_req(2'd0, mk(1'b0, 3, 5, 0));
    #2;
    check("rst_gnt",   32'(bus.req_gnt),  32'h0);
    check("rst_ena",   32'(bus.ena),      32'h0);
    check("rst_rdv",   32'(bus.rd_valid), 32'h0);
    check("rst_err",   32'(bus.req_err),  32'h0);
    check("rst_rdata", 32'(bus.rd_data[0]), 32'h0);
    tick();
    tick();
    clear_reqs();
    rst = 1'b1;

    // Preload bank 3 addr 5, then single read
    set_req(2'd0, mk(1'b1, 3, 5, 16'hBEEF));
    #1;
    check("wr_gnt",  32'(bus.req_gnt), 32'h1);
    check("wr_ena",  32'(bus.ena),     32'h008);
    check("wr_wea",  32'(bus.wea),     32'h008);
    check("wr_dina", 32'(bus.dina[3]), 32'hBEEF);
    tick();
    clear_reqs();
    check("wr_no_rdv", 32'(bus.rd_valid), 32'h0);
    set_req(2'd0, mk(1'b0, 3, 5, 0));
    #1;
    check("rd_gnt",   32'(bus.req_gnt),  32'h1);
    check("rd_ena",   32'(bus.ena),      32'h008);
    check("rd_wea",   32'(bus.wea),      32'h000);
    check("rd_addra", 32'(bus.addra[3]), 32'h5);
    tick();
    clear_reqs();
    check("rd_rdv",   32'(bus.rd_valid),   32'h1);
    check("rd_data",  32'(bus.rd_data[0]), 32'hBEEF);
    tick();
    check("rd_rdv_off", 32'(bus.rd_valid),   32'h0);
    check("rd_hold",    32'(bus.rd_data[0]), 32'hBEEF);

    // Four-way contention on bank 2
    for (int r = 0; r < NR; r++) set_req(2'(r), mk(1'b0, 2, r, 0));
    for (int c = 0; c < 5; c++) begin
      #1;
      check("cont_gnt", 32'(bus.req_gnt), 32'(exp_g[c]));
      check("cont_ena", 32'(bus.ena),     32'h004);
      tick();
      check("cont_rdv", 32'(bus.rd_valid), 32'(exp_g[c]));
    end
    clear_reqs();

    // Parallel banks 0, 1, 9
    set_req(2'd0, mk(1'b0, 0, 1, 0));
    set_req(2'd1, mk(1'b0, 1, 2, 0));
    set_req(2'd2, mk(1'b0, 9, 3, 0));
    #1;
    check("par_gnt", 32'(bus.req_gnt), 32'h7);
    check("par_ena", 32'(bus.ena),     32'h203);
    tick();
    clear_reqs();
    check("par_rdv", 32'(bus.rd_valid), 32'h7);

    // Write then read of the same location on consecutive cycles
    set_req(2'd1, mk(1'b1, 4, 7, 16'h1234));
    #1;
    check("wr2_gnt", 32'(bus.req_gnt), 32'h2);
    check("wr2_wea", 32'(bus.wea),     32'h010);
    tick();
    clear_reqs();
    check("wr2_no_rdv", 32'(bus.rd_valid), 32'h0);
    set_req(2'd2, mk(1'b0, 4, 7, 0));
    #1;
    check("rd2_gnt", 32'(bus.req_gnt), 32'h4);
    tick();
    clear_reqs();
    check("rd2_rdv",  32'(bus.rd_valid),   32'h4);
    check("rd2_data", 32'(bus.rd_data[2]), 32'h1234);

    // Out-of-range bank
    set_req(2'd3, mk(1'b0, 12, 1, 0));
    #1;
    check("oor_gnt", 32'(bus.req_gnt), 32'h8);
    check("oor_ena", 32'(bus.ena),     32'h0);
    tick();
    clear_reqs();
    check("oor_err", 32'(bus.req_err),  32'h8);
    check("oor_rdv", 32'(bus.rd_valid), 32'h0);
    tick();
    check("oor_err_pulse", 32'(bus.req_err), 32'h0);

    // Reset during a read grant; bank 2 pointer sits at r1 here
    for (int r = 0; r < NR; r++) set_req(2'(r), mk(1'b0, 2, r, 0));
    #1;
    check("prerst_gnt", 32'(bus.req_gnt), 32'h2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_gnt", 32'(bus.req_gnt), 32'h0);
    check("midrst_ena", 32'(bus.ena),     32'h0);
    tick();
    check("midrst_rdv", 32'(bus.rd_valid), 32'h0);
    tick();
    rst = 1'b1;
    check("postrst_rdv", 32'(bus.rd_valid), 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_gnt", 32'(bus.req_gnt), 32'(exp_g[c]));
      tick();
      check("post_rdv", 32'(bus.rd_valid), 32'(exp_g[c]));
    end
    clear_reqs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
